// File: rtl/fifo_pkg.sv
// Shared sizing helpers and reset constants for param_fifo and its register file.
// Used by both the default build and the FIFO_ALMOST_FLAGS_EN build.
package fifo_pkg;

    localparam int PTR_RST_VAL   = 0;
    localparam int COUNT_RST_VAL = 0;

    // Pointer width for a power-of-two depth; a depth of 1 would still need one address bit
    function automatic int fifo_addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself
    function automatic int fifo_count_width(input int depth);
        return fifo_addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage array: one synchronous write port, one read port.
// The read data is registered by the parent, so this port is a plain array lookup.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [fifo_addr_width(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]                   wr_data,
    input  logic [fifo_addr_width(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]                   rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with registered, zero-when-idle read data and ack/err pulses.
// Define FIFO_ALMOST_FLAGS_EN to add the almost_full / almost_empty ports (AF_LEVEL / AE_LEVEL).
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
`endif
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [WIDTH-1:0]                    din,
    input  logic                                rd_en,
    output logic [WIDTH-1:0]                    dout,
    output logic [fifo_count_width(DEPTH)-1:0]  data_count,
    output logic                                full,
    output logic                                empty,
`ifdef FIFO_ALMOST_FLAGS_EN
    output logic                                almost_full,
    output logic                                almost_empty,
`endif
    output logic                                wr_ack,
    output logic                                wr_err,
    output logic                                rd_ack,
    output logic                                rd_err
);

    localparam int AW = fifo_addr_width(DEPTH);
    localparam int CW = fifo_count_width(DEPTH);

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_wr_ack;
    logic             r_wr_err;
    logic             r_rd_ack;
    logic             r_rd_err;

    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic             w_re;
    logic [WIDTH-1:0] w_rd_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == CW'(0));

    // A full FIFO still takes a write when a read frees a slot in the same cycle;
    // an empty FIFO never lets a read see the incoming write.
    assign w_we = wr_en & (~w_full | rd_en);
    assign w_re = rd_en & ~w_empty;

    fifo_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we      (w_we & ~reset),
        .wr_addr (r_tail),
        .wr_data (din),
        .rd_addr (r_head),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= AW'(PTR_RST_VAL);
            r_tail   <= AW'(PTR_RST_VAL);
            r_count  <= CW'(COUNT_RST_VAL);
            r_dout   <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_we) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_re) begin
                r_head <= r_head + AW'(1);
            end
            r_count  <= r_count + CW'(w_we) - CW'(w_re);
            r_dout   <= w_re ? w_rd_data : '0;
            r_wr_ack <= w_we;
            r_wr_err <= wr_en & ~w_we;
            r_rd_ack <= w_re;
            r_rd_err <= rd_en & ~w_re;
        end
    end

    assign dout       = r_dout;
    assign data_count = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign wr_ack     = r_wr_ack;
    assign wr_err     = r_wr_err;
    assign rd_ack     = r_rd_ack;
    assign rd_err     = r_rd_err;

`ifdef FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (WIDTH=32, DEPTH=8); almost-flag checks compile only
// when FIFO_ALMOST_FLAGS_EN is defined, with AF_LEVEL=6 and AE_LEVEL=1.
module tb_param_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [WIDTH-1:0]  din;
    logic              rd_en;
    logic [WIDTH-1:0]  dout;
    logic [3:0]        data_count;
    logic              full;
    logic              empty;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .AF_LEVEL (6),
        .AE_LEVEL (1)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
`ifdef FIFO_ALMOST_FLAGS_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic        e_wack;
        logic        e_werr;
        logic        e_rack;
        logic        e_rerr;
        logic [31:0] e_dout;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic wr, input logic rd, input logic [31:0] wdata,
                                    input logic wack, input logic werr, input logic rack,
                                    input logic rerr, input logic [31:0] edout, input logic [3:0] ecnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wdata = wdata;
        v.e_wack = wack; v.e_werr = werr; v.e_rack = rack; v.e_rerr = rerr;
        v.e_dout = edout; v.e_cnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive request at the falling edge, let the rising edge accept it, sample 1 time unit later
    task automatic step(input logic rst, input logic wr, input logic rd, input logic [31:0] wdata);
        @(negedge clk);
        reset = rst;
        wr_en = wr;
        rd_en = rd;
        din   = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] ecnt);
        chk({tag, ".count"}, 32'(data_count), 32'(ecnt));
        chk({tag, ".full"},  32'(full),  32'(ecnt == 4'd8));
        chk({tag, ".empty"}, 32'(empty), 32'(ecnt == 4'd0));
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] w;
        logic [31:0] exp_d;

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        repeat (3) @(posedge clk);

        // Reset, idle
        add_vec(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'd0);
        // Fill 0x11..0x88
        for (int i = 1; i <= 8; i++)
            add_vec(1, 0, 32'(i * 'h11), 1, 0, 0, 0, 32'h0, 4'(i));
        // Ninth write rejected
        add_vec(1, 0, 32'h99, 0, 1, 0, 0, 32'h0, 4'd8);
        // Drain in order
        for (int i = 1; i <= 8; i++)
            add_vec(0, 1, 32'h0, 0, 0, 1, 0, 32'(i * 'h11), 4'(8 - i));
        // Ninth read rejected, dout stays 0
        add_vec(0, 1, 32'h0, 0, 0, 0, 1, 32'h0, 4'd0);
        // Refill, then simultaneous read/write on full
        for (int i = 1; i <= 8; i++)
            add_vec(1, 0, 32'(i * 'h11), 1, 0, 0, 0, 32'h0, 4'(i));
        add_vec(1, 1, 32'hAA, 1, 0, 1, 0, 32'h11, 4'd8);
        for (int i = 2; i <= 8; i++)
            add_vec(0, 1, 32'h0, 0, 0, 1, 0, 32'(i * 'h11), 4'(9 - i));
        add_vec(0, 1, 32'h0, 0, 0, 1, 0, 32'hAA, 4'd0);
        // Simultaneous read/write on empty: write only, no fall-through
        add_vec(1, 1, 32'h55, 1, 0, 0, 1, 32'h0, 4'd1);
        add_vec(0, 1, 32'h0, 0, 0, 1, 0, 32'h55, 4'd0);
        // Idle clears dout
        add_vec(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            step(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            $display("vec %0d wr=%0b rd=%0b din=%h -> dout=%h cnt=%0d wack=%0b werr=%0b rack=%0b rerr=%0b",
                     i, vecs[i].wr, vecs[i].rd, vecs[i].wdata, dout, data_count,
                     wr_ack, wr_err, rd_ack, rd_err);
            chk({tag, ".wr_ack"}, 32'(wr_ack), 32'(vecs[i].e_wack));
            chk({tag, ".wr_err"}, 32'(wr_err), 32'(vecs[i].e_werr));
            chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(vecs[i].e_rack));
            chk({tag, ".rd_err"}, 32'(rd_err), 32'(vecs[i].e_rerr));
            chk({tag, ".dout"},   dout,        vecs[i].e_dout);
            chk_flags(tag, vecs[i].e_cnt);
        end

        // Hold 5 entries while pushing 96 simultaneous read/writes through: 12 pointer wraps
        for (int i = 0; i < 5; i++) begin
            w = 32'hA0 + 32'(i);
            step(1'b0, 1'b1, 1'b0, w);
            q.push_back(w);
        end
        for (int i = 0; i < 96; i++) begin
            w = $urandom;
            step(1'b0, 1'b1, 1'b1, w);
            exp_d = q.pop_front();
            q.push_back(w);
            $display("wrap %0d din=%h -> dout=%h cnt=%0d", i, w, dout, data_count);
            chk("wrap.dout", dout, exp_d);
            chk("wrap.count", 32'(data_count), 32'd5);
        end

        // Reset with both requests pending: no pulses, everything discarded
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        $display("reset dout=%h cnt=%0d wack=%0b werr=%0b rack=%0b rerr=%0b",
                 dout, data_count, wr_ack, wr_err, rd_ack, rd_err);
        chk_flags("rst", 4'd0);
        chk("rst.dout", dout, 32'h0);
        chk("rst.pulses", {28'h0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        $display("post-reset read dout=%h rerr=%0b", dout, rd_err);
        chk("postrst.rd_err", 32'(rd_err), 32'd1);
        chk("postrst.dout", dout, 32'h0);

`ifdef FIFO_ALMOST_FLAGS_EN
        chk("af.idle", 32'(almost_full), 32'd0);
        chk("ae.idle", 32'(almost_empty), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(i));
            $display("almost cnt=%0d af=%0b ae=%0b", data_count, almost_full, almost_empty);
            chk("af.level", 32'(almost_full), 32'(i >= 6));
            chk("ae.level", 32'(almost_empty), 32'(i <= 1));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
